// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: adds one CHUNK-bit slice per clock, LSB slice first,
// behind a valid/ready handshake on both the operand and the result side.
module serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_lhs,
  input  logic [WIDTH-1:0] io_rhs,
  input  logic             io_cin,
  input  logic             io_sub,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_cout,
  output logic             io_ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK < 1) ? 1 : $clog2(NCHUNK + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

  logic [1:0]       state_reg;
  logic [IDXW-1:0]  idx_reg;
  logic             carry_reg;
  logic             armed_reg;
  logic [WIDTH-1:0] lhs_reg;
  logic [WIDTH-1:0] rhs_reg;
  logic [WIDTH-1:0] out_reg;
  logic             cout_reg;
  logic             ovf_reg;

  int               shift;
  logic [CHUNK-1:0] lhs_chunk;
  logic [CHUNK-1:0] rhs_chunk;
  logic [CHUNK:0]   sum;
  logic             msb_carry_in;
  logic [WIDTH-1:0] out_next;
  logic             accept;

  always_comb begin
    shift        = CHUNK * int'(idx_reg);
    lhs_chunk    = CHUNK'(lhs_reg >> shift);
    rhs_chunk    = CHUNK'(rhs_reg >> shift);
    sum          = {1'b0, lhs_chunk} + {1'b0, rhs_chunk} + {{CHUNK{1'b0}}, carry_reg};
    // Carry into the top bit of the slice, recovered from that bit's half-sum.
    msb_carry_in = lhs_chunk[CHUNK-1] ^ rhs_chunk[CHUNK-1] ^ sum[CHUNK-1];
    out_next     = (out_reg & ~(CHUNK_MASK << shift)) | (WIDTH'(sum[CHUNK-1:0]) << shift);
  end

  // armed_reg keeps the edge that releases reset from ever accepting an operand.
  assign accept       = io_in_valid && (state_reg == IDLE) && armed_reg;
  assign io_in_ready  = (state_reg == IDLE);
  assign io_out_valid = (state_reg == DONE);
  assign io_out       = out_reg;
  assign io_cout      = cout_reg;
  assign io_ovf       = ovf_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      armed_reg <= 1'b0;
      lhs_reg   <= '0;
      rhs_reg   <= '0;
      out_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            lhs_reg   <= io_lhs;
            rhs_reg   <= io_sub ? ~io_rhs : io_rhs;
            carry_reg <= io_sub ? ~io_cin : io_cin;
            idx_reg   <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          out_reg   <= out_next;
          carry_reg <= sum[CHUNK];
          idx_reg   <= idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_reg <= DONE;
            cout_reg  <= sum[CHUNK];
            ovf_reg   <= msb_carry_in ^ sum[CHUNK];
          end
        end
        DONE: begin
          if (io_out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port io_in_valid  input  1  operand set offered.
REQ-006 SHALL have port io_in_ready  output  1  block can accept operands.
REQ-007 SHALL have port io_lhs  input  WIDTH  left operand.
REQ-008 SHALL have port io_rhs  input  WIDTH  right operand.
REQ-009 SHALL have port io_cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 SHALL have port io_sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port io_out_valid  output  1  result available.
REQ-012 SHALL have port io_out_ready  input  1  consumer takes result.
REQ-013 SHALL have port io_out  output  WIDTH  sum/difference.
REQ-014 SHALL have port io_cout  output  1  carry out of MSB.
REQ-015 SHALL have port io_ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 SHALL drive io_in_ready = 1 only in IDLE, io_out_valid = 1 only in DONE, both decoded from state.
REQ-018 Acceptance: io_in_valid && io_in_ready at a rising edge SHALL register io_lhs, io_rhs, io_sub, io_cin, clear the chunk index to 0, and move to BUSY.
REQ-019 Registered effective rhs SHALL be io_sub ? ~io_rhs : io_rhs; initial carry SHALL be io_sub ? ~io_cin : io_cin.
REQ-020 Each BUSY edge SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK, LSB chunk first) of lhs, effective rhs and carry, write the CHUNK-bit sum into result chunk k, update the carry, and increment k.
REQ-021 On the edge processing chunk NCHUNK-1, the FSM SHALL move to DONE, set io_cout to the final carry, and set io_ovf = carry into MSB XOR carry out of MSB.
REQ-022 Latency: io_out_valid SHALL rise exactly NCHUNK cycles after the acceptance edge; when NCHUNK = 1, one cycle.
REQ-023 In DONE, io_out, io_cout, io_ovf SHALL hold stable until io_out_ready is 1; on that edge the FSM SHALL return to IDLE.
REQ-024 io_in_valid SHALL be ignored in BUSY and DONE; acceptance and result transfer never occur in the same cycle.
REQ-025 io_out, io_cout, io_ovf SHALL retain the last result in IDLE and BUSY until overwritten; only io_out_valid qualifies them.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; io_cout = 1 in subtract mode means no borrow.
REQ-027 The chunk index SHALL be ceil(log2(NCHUNK+1)) bits wide (minimum 1) and SHALL NOT wrap within an operation.

Reset
REQ-028 reset low SHALL immediately, without clk, force state to IDLE, chunk index 0, carry 0, io_out 0, io_cout 0, io_ovf 0, io_out_valid 0, io_in_ready 1.
REQ-029 reset asserted mid-BUSY or in DONE SHALL discard the operation; the first acceptance after release SHALL compute correctly.
REQ-030 No operand SHALL be accepted on the rising edge on which reset is released.

Verification (WIDTH=8, CHUNK=4 unless stated)
REQ-031 add 0x0F + 0x01, cin=0 -> io_out=0x10, cout=0, ovf=0, io_out_valid high 2 cycles after acceptance.
REQ-032 add 0x7F + 0x01 -> 0x80, cout=0, ovf=1; add 0xFF + 0x00, cin=1 -> 0x00, cout=1, ovf=0.
REQ-033 sub 0x05 - 0x07, cin=0 -> 0xFE, cout=0, ovf=0; sub 0x80 - 0x01 -> 0x7F, cout=1, ovf=1.
REQ-034 io_out_ready held 0 for 5 cycles in DONE with io_in_valid=1 and changing operands -> outputs stable, io_in_ready=0, no acceptance; io_out_ready=1 -> IDLE next cycle.
REQ-035 reset pulsed low during BUSY -> all outputs 0 and io_in_ready=1 asynchronously; next op 0x12 + 0x34 -> 0x46.
REQ-036 WIDTH=8, CHUNK=8: 0xC8 + 0x64 -> 0x2C, cout=1, ovf=0, latency 1 cycle.
